// File: rtl/bcd_time_loader_pkg.sv
// Shared constants and types for the operator-side BCD duration loader.
// Digit width, default limits, target-select encoding and FSM states.
package bcd_time_loader_pkg;

    localparam int BCD_W       = 4;
    localparam int NUM_DIGITS  = 3;
    localparam int OUT_W_DEF   = 7;
    localparam int BIN_W_DEF   = 8;
    localparam int MIN_VAL_DEF = 5;
    localparam int MAX_VAL_DEF = 120;

    localparam logic SEL_DATA0 = 1'b0;
    localparam logic SEL_DATA1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D1     = 3'd1,
        ST_D2     = 3'd2,
        ST_CONV   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RESULT = 3'd5
    } state_e;

    function automatic logic bcd_digit_bad(input logic [BCD_W-1:0] d);
        return (d > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_time_loader_if.sv
// Digit-entry and result handshake bundle of the BCD time loader.
// master = operator/consumer side, slave = loader.
interface bcd_time_loader_if #(parameter int OUT_W = 7);

    logic             abort;
    logic [3:0]       digit;
    logic             digit_sel;
    logic             digit_valid;
    logic             digit_ready;
    logic [OUT_W-1:0] out_value;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;
    logic             err_digit;
    logic             err_range;
    logic             busy;

    modport master (
        output abort, digit, digit_sel, digit_valid, out_ready,
        input  digit_ready, out_value, out_sel, out_valid, err_digit, err_range, busy
    );

    modport slave (
        input  abort, digit, digit_sel, digit_valid, out_ready,
        output digit_ready, out_value, out_sel, out_valid, err_digit, err_range, busy
    );

endinterface

// File: rtl/bcd_time_loader_nibble_adj.sv
// Reverse double-dabble correction for one BCD nibble after a right shift.
module bcd_nibble_adj
    import bcd_time_loader_pkg::*;
(
    input  logic [BCD_W-1:0] nib_i,
    output logic [BCD_W-1:0] nib_o
);

    // Subtract 3 from any nibble that received a shifted-in 10's weight.
    always_comb begin
        if (nib_i >= 4'd8) begin
            nib_o = nib_i - 4'd3;
        end else begin
            nib_o = nib_i;
        end
    end

endmodule

// File: rtl/bcd_time_loader.sv
// Serial 3-digit BCD to binary loader: digit entry FSM, 1-bit/cycle reverse
// double-dabble, range check and a valid/ready result port with target select.
module bcd_time_loader
    import bcd_time_loader_pkg::*;
#(
    parameter int OUT_W   = OUT_W_DEF,
    parameter int BIN_W   = BIN_W_DEF,
    parameter int MIN_VAL = MIN_VAL_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    bcd_time_loader_if.slave bus
);

    localparam int BCD_TOT = NUM_DIGITS * BCD_W;
    localparam int SR_W    = BCD_TOT + BIN_W;
    localparam int CNT_W   = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] MIN_B    = BIN_W'(MIN_VAL);
    localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [BCD_W-1:0]   digit_q, digit_d;
    logic               load_pend_q, load_pend_d;
    logic               sel_q, sel_d;
    logic [OUT_W-1:0]   out_value_q, out_value_d;
    logic               out_sel_q, out_sel_d;
    logic               out_valid_q, out_valid_d;
    logic               err_digit_q, err_digit_d;
    logic               err_range_q, err_range_d;
    logic               digit_ready_q, digit_ready_d;
    logic               busy_q, busy_d;

    logic               transfer_s;
    logic               bad_s;
    logic [SR_W-1:0]    shifted_s;
    logic [BCD_TOT-1:0] adj_s;
    logic [SR_W-1:0]    conv_s;
    logic [SR_W-1:0]    load_s;
    logic [BIN_W-1:0]   bin_s;
    logic               in_range_s;

    assign transfer_s = bus.digit_valid & digit_ready_q;
    assign bad_s      = bcd_digit_bad(bus.digit);

    assign shifted_s = sr_q >> 1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib_i (shifted_s[BIN_W + g*BCD_W +: BCD_W]),
            .nib_o (adj_s[g*BCD_W +: BCD_W])
        );
    end
    assign conv_s = {adj_s, shifted_s[BIN_W-1:0]};

    // Accepted digits reach the BCD register one cycle later, units last.
    assign load_s = {sr_q[SR_W-BCD_W-1:BIN_W], digit_q, {BIN_W{1'b0}}};

    // Any BCD residue after all shifts means the value did not fit in BIN_W bits.
    assign bin_s      = sr_q[BIN_W-1:0];
    assign in_range_s = (sr_q[SR_W-1:BIN_W] == {BCD_TOT{1'b0}}) &&
                        (bin_s >= MIN_B) && (bin_s <= MAX_B);

    // Shift register datapath: pending digit load has priority over a conversion step.
    always_comb begin
        if (load_pend_q) begin
            sr_d = load_s;
        end else if (state_q == ST_CONV) begin
            sr_d = conv_s;
        end else begin
            sr_d = sr_q;
        end
    end

    // Next-state and output-register logic of the entry/convert/result FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        digit_d     = digit_q;
        load_pend_d = 1'b0;
        sel_d       = sel_q;
        out_value_d = out_value_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        err_digit_d = 1'b0;
        err_range_d = 1'b0;

        if (bus.abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_D1, ST_D2: begin
                    if (transfer_s && bad_s) begin
                        err_digit_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (transfer_s) begin
                        digit_d     = bus.digit;
                        load_pend_d = 1'b1;
                        case (state_q)
                            ST_IDLE: begin
                                sel_d   = bus.digit_sel;
                                state_d = ST_D1;
                            end
                            ST_D1: begin
                                state_d = ST_D2;
                            end
                            default: begin
                                cnt_d   = CNT_LAST;
                                state_d = ST_CONV;
                            end
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CONV: begin
                    if (load_pend_q) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_CHECK: begin
                    if (in_range_s) begin
                        out_value_d = bin_s[OUT_W-1:0];
                        out_sel_d   = sel_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_RESULT;
                    end else begin
                        err_range_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_RESULT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end

        // A rejected digit costs one dead cycle so error pulses cannot run back to back.
        digit_ready_d = ((state_d == ST_IDLE) || (state_d == ST_D1) || (state_d == ST_D2))
                        && !err_digit_d;
        busy_d        = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            sr_q          <= {SR_W{1'b0}};
            digit_q       <= {BCD_W{1'b0}};
            load_pend_q   <= 1'b0;
            sel_q         <= SEL_DATA0;
            out_value_q   <= {OUT_W{1'b0}};
            out_sel_q     <= SEL_DATA0;
            out_valid_q   <= 1'b0;
            err_digit_q   <= 1'b0;
            err_range_q   <= 1'b0;
            digit_ready_q <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            digit_q       <= digit_d;
            load_pend_q   <= load_pend_d;
            sel_q         <= sel_d;
            out_value_q   <= out_value_d;
            out_sel_q     <= out_sel_d;
            out_valid_q   <= out_valid_d;
            err_digit_q   <= err_digit_d;
            err_range_q   <= err_range_d;
            digit_ready_q <= digit_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.digit_ready = digit_ready_q;
    assign bus.out_value   = out_value_q;
    assign bus.out_sel     = out_sel_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.err_digit   = err_digit_q;
    assign bus.err_range   = err_range_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bcd_time_loader.sv
// Self-checking bench for bcd_time_loader: vector table of 3-digit entries plus
// hand sequences for back-pressure, bad digits, abort and asynchronous reset.
module tb_bcd_time_loader;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    bcd_time_loader_if #(.OUT_W(7)) bus ();

    bcd_time_loader #(
        .OUT_W   (7),
        .BIN_W   (8),
        .MIN_VAL (5),
        .MAX_VAL (120)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        logic       sel;
        logic       ok;
        int         val;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one digit, waiting (bounded) for digit_ready; returns after the transfer edge.
    task automatic send_digit(input logic [3:0] d, input logic s);
        int waited;
        waited = 0;
        while (!bus.digit_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.digit_ready) chk("digit_ready_timeout", 32'd0, 32'd1);
        bus.digit       = d;
        bus.digit_sel   = s;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    // Full entry; waits up to 20 cycles for out_valid or err_range after the 3rd digit.
    task automatic run_entry(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                             input logic s, output logic saw_valid, output logic saw_err,
                             output int lat, output logic [6:0] val, output logic vsel);
        saw_valid = 1'b0;
        saw_err   = 1'b0;
        lat       = 0;
        val       = 7'd0;
        vsel      = 1'b0;
        send_digit(h, s);
        send_digit(t, ~s);
        send_digit(u, ~s);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.out_valid || bus.err_range) begin
                saw_valid = bus.out_valid;
                saw_err   = bus.err_range;
                lat       = k;
                val       = bus.out_value;
                vsel      = bus.out_sel;
                break;
            end
        end
    endtask

    logic       sv, se, vs;
    int         lat;
    logic [6:0] vv;

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        reset           = 1'b1;
        bus.abort       = 1'b0;
        bus.digit       = 4'd0;
        bus.digit_sel   = 1'b0;
        bus.digit_valid = 1'b0;
        bus.out_ready   = 1'b1;

        vecs[0] = '{h:4'd0, t:4'd3, u:4'd0, sel:1'b0, ok:1'b1, val:30};
        vecs[1] = '{h:4'd0, t:4'd0, u:4'd5, sel:1'b1, ok:1'b1, val:5};
        vecs[2] = '{h:4'd1, t:4'd2, u:4'd0, sel:1'b1, ok:1'b1, val:120};
        vecs[3] = '{h:4'd1, t:4'd2, u:4'd1, sel:1'b0, ok:1'b0, val:0};
        vecs[4] = '{h:4'd0, t:4'd0, u:4'd4, sel:1'b0, ok:1'b0, val:0};
        vecs[5] = '{h:4'd0, t:4'd9, u:4'd9, sel:1'b0, ok:1'b1, val:99};
        vecs[6] = '{h:4'd0, t:4'd4, u:4'd7, sel:1'b1, ok:1'b1, val:47};
        vecs[7] = '{h:4'd0, t:4'd0, u:4'd0, sel:1'b0, ok:1'b0, val:0};
        vecs[8] = '{h:4'd3, t:4'd0, u:4'd0, sel:1'b1, ok:1'b0, val:0};
        vecs[9] = '{h:4'd1, t:4'd9, u:4'd9, sel:1'b0, ok:1'b0, val:0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_digit_ready", 32'(bus.digit_ready), 32'd1);
        chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
        chk("rst_out_value",   32'(bus.out_value),   32'd0);
        chk("rst_busy",        32'(bus.busy),        32'd0);
        reset = 1'b0;
        tick();

        // Table of complete entries with out_ready held high.
        for (int i = 0; i < 10; i++) begin
            run_entry(vecs[i].h, vecs[i].t, vecs[i].u, vecs[i].sel, sv, se, lat, vv, vs);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd10);
            chk($sformatf("v%0d_valid", i), 32'(sv), 32'(vecs[i].ok));
            chk($sformatf("v%0d_err_range", i), 32'(se), 32'(!vecs[i].ok));
            if (vecs[i].ok) begin
                chk($sformatf("v%0d_value", i), 32'(vv), 32'(vecs[i].val));
                chk($sformatf("v%0d_sel", i), 32'(vs), 32'(vecs[i].sel));
            end else begin
                chk($sformatf("v%0d_err_digit", i), 32'(bus.err_digit), 32'd0);
            end
            tick();
            chk($sformatf("v%0d_valid_pulse", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("v%0d_err_pulse", i), 32'(bus.err_range), 32'd0);
            chk($sformatf("v%0d_idle", i), 32'(bus.busy), 32'd0);
        end

        // Back-pressure: result held 5 cycles, stray digits ignored.
        bus.out_ready = 1'b0;
        run_entry(4'd1, 4'd2, 4'd0, 1'b1, sv, se, lat, vv, vs);
        chk("bp_valid", 32'(sv), 32'd1);
        bus.digit       = 4'd7;
        bus.digit_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.out_valid),   32'd1);
            chk("bp_hold_value", 32'(bus.out_value),   32'd120);
            chk("bp_hold_sel",   32'(bus.out_sel),     32'd1);
            chk("bp_hold_ready", 32'(bus.digit_ready), 32'd0);
        end
        bus.digit_valid = 1'b0;
        bus.out_ready   = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.out_valid),   32'd0);
        chk("bp_release_busy",  32'(bus.busy),        32'd0);
        chk("bp_release_ready", 32'(bus.digit_ready), 32'd1);
        chk("bp_keep_value",    32'(bus.out_value),   32'd120);

        // Bad second digit: one-cycle err_digit, back to idle.
        send_digit(4'd0, 1'b0);
        send_digit(4'hA, 1'b0);
        chk("bad_err_digit", 32'(bus.err_digit), 32'd1);
        chk("bad_busy",      32'(bus.busy),      32'd0);
        chk("bad_err_range", 32'(bus.err_range), 32'd0);
        tick();
        chk("bad_err_pulse", 32'(bus.err_digit),   32'd0);
        chk("bad_ready",     32'(bus.digit_ready), 32'd1);
        run_entry(4'd0, 4'd9, 4'd9, 1'b0, sv, se, lat, vv, vs);
        chk("after_bad_valid", 32'(sv), 32'd1);
        chk("after_bad_value", 32'(vv), 32'd99);
        tick();

        // Abort in the 4th conversion cycle: no result, no error.
        send_digit(4'd0, 1'b0);
        send_digit(4'd3, 1'b0);
        send_digit(4'd0, 1'b0);
        repeat (3) tick();
        chk("conv_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_conv_busy",  32'(bus.busy),        32'd0);
        chk("abort_conv_ready", 32'(bus.digit_ready), 32'd1);
        chk("abort_conv_valid", 32'(bus.out_valid),   32'd0);
        sv = 1'b0;
        se = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            sv = sv | bus.out_valid;
            se = se | bus.err_range | bus.err_digit;
        end
        chk("abort_conv_no_valid", 32'(sv), 32'd0);
        chk("abort_conv_no_err",   32'(se), 32'd0);

        // Abort in RESULT, with out_ready also high.
        bus.out_ready = 1'b0;
        run_entry(4'd0, 4'd4, 4'd7, 1'b0, sv, se, lat, vv, vs);
        chk("abort_res_valid", 32'(sv), 32'd1);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_res_out_valid", 32'(bus.out_valid),   32'd0);
        chk("abort_res_busy",      32'(bus.busy),        32'd0);
        chk("abort_res_ready",     32'(bus.digit_ready), 32'd1);
        chk("abort_res_err",       32'(bus.err_range | bus.err_digit), 32'd0);

        // Asynchronous reset mid-conversion, then a clean entry.
        send_digit(4'd0, 1'b1);
        send_digit(4'd5, 1'b0);
        send_digit(4'd0, 1'b0);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        chk("areset_busy",      32'(bus.busy),        32'd0);
        chk("areset_ready",     32'(bus.digit_ready), 32'd1);
        chk("areset_value",     32'(bus.out_value),   32'd0);
        chk("areset_out_valid", 32'(bus.out_valid),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_entry(4'd0, 4'd6, 4'd0, 1'b0, sv, se, lat, vv, vs);
        chk("post_reset_valid", 32'(sv),  32'd1);
        chk("post_reset_value", 32'(vv),  32'd60);
        chk("post_reset_lat",   32'(lat), 32'd10);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
